// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Takes a length-prefixed byte stream over valid/ready and packs the bytes
// little-endian into 32-bit words. The words go to consecutive addresses
// starting at 0. The core is held in reset until the whole image is written.
// Optional feature: define IMEM_LOADER_CKSUM_EN to expect a trailing XOR
// checksum byte after the payload.
module imem_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              err
);

  // Number of memory words, widened by one bit so that DEPTH == 2**16 still fits.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

`ifdef IMEM_LOADER_CKSUM_EN
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CKSUM, S_DONE, S_ERR} state_t;
  localparam state_t S_TAIL = S_CKSUM;
`else
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR} state_t;
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t            state, state_nxt;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [15:0]       len_full;
  logic [1:0]        byte_cnt;
  logic [15:0]       word_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [23:0]       pack;
  logic              accept;
  logic              word_done;
  logic              last_word;
  logic              reload_go;
  logic              done_nxt;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]        xor_acc;
`endif

  // Handshake and word-completion decode
  always_comb begin
    rx_ready  = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA)
`ifdef IMEM_LOADER_CKSUM_EN
                || (state == S_CKSUM)
`endif
                ;
    accept    = rx_valid && rx_ready;
    len_full  = {rx_data, len_lo};
    last_word = (word_cnt == (len - 16'd1));
    word_done = (state == S_DATA) && accept && (byte_cnt == 2'd3);
    reload_go = reload && ((state == S_DONE) || (state == S_ERR));
    done_nxt  = (state == S_DONE) && !reload;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_LEN0;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN0: if (accept) state_nxt = S_LEN1;
      S_LEN1:
        if (accept) begin
          if ({1'b0, len_full} > DEPTH) state_nxt = S_ERR;
          else if (len_full == 16'd0)   state_nxt = S_TAIL;
          else                          state_nxt = S_DATA;
        end
      S_DATA: if (word_done && last_word) state_nxt = S_TAIL;
`ifdef IMEM_LOADER_CKSUM_EN
      S_CKSUM:
        if (accept) state_nxt = (rx_data == xor_acc) ? S_DONE : S_ERR;
`endif
      S_DONE: if (reload) state_nxt = S_LEN0;
      S_ERR:  if (reload) state_nxt = S_LEN0;
      default: state_nxt = S_LEN0;
    endcase
  end

  // Length capture, byte packing and word/address counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_lo   <= '0;
      len      <= '0;
      byte_cnt <= '0;
      word_cnt <= '0;
      addr_cnt <= '0;
      pack     <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      xor_acc  <= '0;
`endif
    end else if (reload_go) begin
      byte_cnt <= '0;
      word_cnt <= '0;
      addr_cnt <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      xor_acc  <= '0;
`endif
    end else begin
      if (state == S_LEN0 && accept) len_lo <= rx_data;
      if (state == S_LEN1 && accept) len    <= len_full;
      if (state == S_DATA && accept) begin
        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
        xor_acc  <= xor_acc ^ rx_data;
`endif
        case (byte_cnt)
          2'd0: pack[7:0]   <= rx_data;
          2'd1: pack[15:8]  <= rx_data;
          2'd2: pack[23:16] <= rx_data;
          default: begin
            word_cnt <= word_cnt + 16'd1;
            // Hold the address on the final word so N == DEPTH never wraps to 0.
            if (!last_word) addr_cnt <= addr_cnt + ADDR_W'(1);
          end
        endcase
      end
    end
  end

  // Registered memory write port and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= word_done;
      if (word_done) begin
        imem_addr  <= addr_cnt;
        imem_wdata <= {rx_data, pack};
      end
      // done trails entry into DONE by one edge so release follows the final write cycle.
      done       <= done_nxt;
      core_reset <= !done_nxt;
      err        <= (state_nxt == S_ERR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (ADDR_W = 4, DEPTH = 16).
// Writes expected by the stimulus are queued and consumed by a write monitor.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        reload;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_count = 0;
  logic [35:0] exp_q[$];
  logic [31:0] words[$];
  logic [35:0] mon_exp;

  imem_loader #(.ADDR_W(4)) dut (
    .clk(clk), .reset(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .reload(reload), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset(core_reset), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest queued expectation
  always @(posedge clk) begin
    #1;
    if (imem_we === 1'b1) begin
      wr_count++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL write_unexpected addr=%0d data=%08h required=no write", imem_addr, imem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== mon_exp) begin
          n_bad++;
          $display("FAIL write addr/data got=%0d/%08h required=%0d/%08h",
                   imem_addr, imem_wdata, mon_exp[35:32], mon_exp[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Sends the frame held in words[]; returns #1 after the final byte's edge.
  task automatic send_frame(input int gap, input logic [7:0] ck_flip);
    logic [15:0] n;
    logic [31:0] w;
    logic [7:0]  x;
    logic [7:0]  b;
    n = 16'(words.size());
    x = 8'h00;
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    for (int k = 0; k < words.size(); k++) begin
      w = words[k];
      for (int j = 0; j < 4; j++) begin
        b = w[8*j +: 8];
        x = x ^ b;
        if (j == 3) exp_q.push_back({4'(k), w});
        send_byte(b, gap);
      end
    end
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(x ^ ck_flip, gap);
`else
    if (ck_flip != 8'h00) x = 8'h00;
`endif
  endtask

  task automatic reload_pulse();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (rx_ready !== 1'b1)    begin n_bad++; $display("FAIL reset_rx_ready got=%b required=1", rx_ready); end
    n_cmp++; if (imem_we !== 1'b0)     begin n_bad++; $display("FAIL reset_imem_we got=%b required=0", imem_we); end
    n_cmp++; if (imem_addr !== 4'd0)   begin n_bad++; $display("FAIL reset_imem_addr got=%0d required=0", imem_addr); end
    n_cmp++; if (imem_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_imem_wdata got=%08h required=0", imem_wdata); end
    n_cmp++; if (core_reset !== 1'b1)  begin n_bad++; $display("FAIL reset_core_reset got=%b required=1", core_reset); end
    n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_done_err got=%b%b required=00", done, err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int w0;
    w0 = wr_count;
    words = '{32'h00000013, 32'h005000B3};
    send_frame(0, 8'h00);
    n_cmp++; if (done !== 1'b0 || core_reset !== 1'b1) begin n_bad++; $display("FAIL basic_early_release done/core_reset got=%b/%b required=0/1", done, core_reset); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b1 || core_reset !== 1'b0) begin n_bad++; $display("FAIL basic_release done/core_reset got=%b/%b required=1/0", done, core_reset); end
    n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL basic_rx_ready_done got=%b required=0", rx_ready); end
    n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL basic_we_after got=%b required=0", imem_we); end
    n_cmp++; if (wr_count - w0 != 2 || exp_q.size() != 0) begin n_bad++; $display("FAIL basic_write_count got=%0d pending=%0d required=2/0", wr_count - w0, exp_q.size()); end
  endtask

  task automatic test_reload();
    int w0;
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    n_cmp++; if (core_reset !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL reload_state core_reset/done got=%b/%b required=1/0", core_reset, done); end
    n_cmp++; if (rx_ready !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL reload_ready rx_ready/err got=%b/%b required=1/0", rx_ready, err); end
    w0 = wr_count;
    words = '{32'h12345678};
    send_frame(0, 8'h00);
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b1 || core_reset !== 1'b0) begin n_bad++; $display("FAIL reload_frame_done got=%b/%b required=1/0", done, core_reset); end
    n_cmp++; if (wr_count - w0 != 1 || exp_q.size() != 0) begin n_bad++; $display("FAIL reload_write_count got=%0d required=1", wr_count - w0); end
  endtask

  task automatic test_gaps();
    int w0;
    reload_pulse();
    w0 = wr_count;
    words = '{32'hCAFEF00D};
    send_frame(3, 8'h00);
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL gaps_done got=%b required=1", done); end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (wr_count - w0 != 1 || exp_q.size() != 0) begin n_bad++; $display("FAIL gaps_write_count got=%0d required=1", wr_count - w0); end
  endtask

  task automatic test_len_err();
    int w0;
    reload_pulse();
    w0 = wr_count;
    send_byte(8'h11, 0);
    send_byte(8'h00, 0);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL len_err_flag got=%b required=1", err); end
    n_cmp++; if (rx_ready !== 1'b0 || core_reset !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL len_err_outputs rx_ready/core_reset/done got=%b/%b/%b required=0/1/0", rx_ready, core_reset, done); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    n_cmp++; if (err !== 1'b1 || wr_count != w0) begin n_bad++; $display("FAIL len_err_hold err/writes got=%b/%0d required=1/0", err, wr_count - w0); end
  endtask

  task automatic test_full_depth();
    int w0;
    reload_pulse();
    w0 = wr_count;
    words.delete();
    for (int k = 0; k < 16; k++) words.push_back($urandom);
    send_frame(0, 8'h00);
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL depth_done done/err got=%b/%b required=1/0", done, err); end
    n_cmp++; if (wr_count - w0 != 16 || exp_q.size() != 0) begin n_bad++; $display("FAIL depth_write_count got=%0d required=16", wr_count - w0); end
  endtask

  task automatic test_zero_len();
    int w0;
    reload_pulse();
    w0 = wr_count;
    words.delete();
    send_frame(0, 8'h00);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_early_done got=%b required=0", done); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b1 || core_reset !== 1'b0) begin n_bad++; $display("FAIL zero_done got=%b/%b required=1/0", done, core_reset); end
    n_cmp++; if (wr_count != w0) begin n_bad++; $display("FAIL zero_writes got=%0d required=0", wr_count - w0); end
  endtask

  task automatic test_reset_mid();
    int w0;
    reload_pulse();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (core_reset !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_ctrl core_reset/done/rx_ready got=%b/%b/%b required=1/0/1", core_reset, done, rx_ready); end
    n_cmp++; if (imem_we !== 1'b0 || imem_addr !== 4'd0 || imem_wdata !== 32'd0) begin n_bad++; $display("FAIL midreset_port got=%b/%0d/%08h required=0/0/0", imem_we, imem_addr, imem_wdata); end
    @(negedge clk);
    rst = 1'b0;
    w0 = wr_count;
    words = '{32'hDDCCBBAA};
    send_frame(0, 8'h00);
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL midreset_done got=%b required=1", done); end
    n_cmp++; if (wr_count - w0 != 1 || exp_q.size() != 0) begin n_bad++; $display("FAIL midreset_writes got=%0d required=1", wr_count - w0); end
  endtask

`ifdef IMEM_LOADER_CKSUM_EN
  task automatic test_cksum();
    reload_pulse();
    words = '{32'h08040201};
    send_frame(0, 8'h00);
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL cksum_good done/err got=%b/%b required=1/0", done, err); end
    reload_pulse();
    send_frame(0, 8'h01);
    n_cmp++; if (err !== 1'b1 || core_reset !== 1'b1 || rx_ready !== 1'b0) begin n_bad++; $display("FAIL cksum_bad err/core_reset/rx_ready got=%b/%b/%b required=1/1/0", err, core_reset, rx_ready); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0 || err !== 1'b1) begin n_bad++; $display("FAIL cksum_bad_hold done/err got=%b/%b required=0/1", done, err); end
    reload_pulse();
    n_cmp++; if (err !== 1'b0 || rx_ready !== 1'b1) begin n_bad++; $display("FAIL cksum_reload err/rx_ready got=%b/%b required=0/1", err, rx_ready); end
    send_frame(0, 8'h00);
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b1 || core_reset !== 1'b0) begin n_bad++; $display("FAIL cksum_retry done/core_reset got=%b/%b required=1/0", done, core_reset); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_reload();
    test_gaps();
    test_len_err();
    test_full_depth();
    test_zero_len();
    test_reset_mid();
`ifdef IMEM_LOADER_CKSUM_EN
    test_cksum();
`endif
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_writes got=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
